// File: rtl/mem_arbiter.sv
// Purpose: three-requester round-robin burst arbiter onto one memory port, with in-order read tag tracking.
// Latency: first memory beat 1 cycle after a request is seen in IDLE; read response 1 cycle after mem_rvalid.
// Backpressure: beats stall on mem_ready, and reads also stall while the owner tag queue is full.
//
// Ports:
//   wb_clk_i, wb_rst_i          clock, asynchronous active-high reset
//   req_valid/we/len/addr/wdata per-requester beat request (index 0=CPU, 1=FIR DMA, 2=matmul/qsort DMA)
//   req_ready                   per-requester beat accepted this cycle
//   rsp_valid, rsp_rdata        per-requester read-data strobe, shared read data
//   mem_req/we/addr/wdata       shared memory beat request
//   mem_ready                   memory accepts the current beat
//   mem_rvalid, mem_rdata       in-order read return from memory
//   gnt_id, busy                current owner, burst in progress
//   err_orphan, err_abort       sticky: read return with no owner, burst killed by watchdog

// Generic FIFO for small bookkeeping queues.
// Latency: rd_dat shows the head combinationally; a push is visible the cycle after its edge.
// Backpressure: full/empty exported; a push while full or a pop while empty is dropped.
module fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             wr_vld,
    input  logic [WIDTH-1:0] wr_dat,
    input  logic             rd_rdy,
    output logic [WIDTH-1:0] rd_dat,
    output logic             full,
    output logic             empty
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] store [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [CNT_W-1:0] count;
    logic             do_wr;
    logic             do_rd;

    assign full   = (count == CNT_W'(DEPTH));
    assign empty  = (count == '0);
    assign do_wr  = wr_vld && !full;
    assign do_rd  = rd_rdy && !empty;
    assign rd_dat = store[rd_ptr];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_wr) wr_ptr <= wr_ptr + PTR_W'(1);
            if (do_rd) rd_ptr <= rd_ptr + PTR_W'(1);
            // Simultaneous push and pop leave occupancy unchanged.
            if (do_wr && !do_rd)
                count <= count + CNT_W'(1);
            else if (!do_wr && do_rd)
                count <= count - CNT_W'(1);
        end
    end

    // Storage needs no reset: entries are only read while the count says they are valid.
    always_ff @(posedge clk) begin
        if (do_wr) store[wr_ptr] <= wr_dat;
    end
endmodule

module mem_arbiter #(
    parameter int ADDR_W     = 23,
    parameter int TAGQ_DEPTH = 4,
    parameter int WDOG       = 16
) (
    input  logic                  wb_clk_i,
    input  logic                  wb_rst_i,
    input  logic [2:0]            req_valid,
    input  logic [2:0]            req_we,
    input  logic [8:0]            req_len,
    input  logic [3*ADDR_W-1:0]   req_addr,
    input  logic [95:0]           req_wdata,
    output logic [2:0]            req_ready,
    output logic [2:0]            rsp_valid,
    output logic [31:0]           rsp_rdata,
    output logic                  mem_req,
    output logic                  mem_we,
    output logic [ADDR_W-1:0]     mem_addr,
    output logic [31:0]           mem_wdata,
    input  logic                  mem_ready,
    input  logic                  mem_rvalid,
    input  logic [31:0]           mem_rdata,
    output logic [1:0]            gnt_id,
    output logic                  busy,
    output logic                  err_orphan,
    output logic                  err_abort
);
    localparam logic [0:0] IDLE  = 1'b0;
    localparam logic [0:0] BURST = 1'b1;
    localparam int         WDOG_W = $clog2(WDOG + 1);

    logic [0:0]        state;
    logic [1:0]        rr_ptr;
    logic [3:0]        beat_cnt;
    logic [WDOG_W-1:0] wdog_cnt;

    // Per-requester views padded to four entries so a 2-bit owner index never leaves the array.
    logic [2:0]        len_a   [4];
    logic [ADDR_W-1:0] addr_a  [4];
    logic [31:0]       wdata_a [4];
    logic [3:0]        vld_x;
    logic [3:0]        we_x;

    logic [1:0] sel;
    logic       in_burst;
    logic       own_vld;
    logic       own_rd;
    logic       accept;
    logic       last_beat;
    logic       wdog_fire;
    logic [1:0] next_rr;
    logic       tag_push;
    logic [1:0] tag_head;
    logic       tagq_full;
    logic       tagq_empty;

    always_comb begin
        for (int i = 0; i < 3; i++) begin
            len_a[i]   = req_len[i*3 +: 3];
            addr_a[i]  = req_addr[i*ADDR_W +: ADDR_W];
            wdata_a[i] = req_wdata[i*32 +: 32];
        end
        len_a[3]   = '0;
        addr_a[3]  = '0;
        wdata_a[3] = '0;
    end

    assign vld_x = {1'b0, req_valid};
    assign we_x  = {1'b0, req_we};

    // First requesting index at or after rr_ptr, wrapping modulo 3.
    always_comb begin
        sel = 2'd0;
        case (rr_ptr)
            2'd1:    sel = req_valid[1] ? 2'd1 : (req_valid[2] ? 2'd2 : 2'd0);
            2'd2:    sel = req_valid[2] ? 2'd2 : (req_valid[0] ? 2'd0 : 2'd1);
            default: sel = req_valid[0] ? 2'd0 : (req_valid[1] ? 2'd1 : 2'd2);
        endcase
    end

    assign in_burst = (state == BURST);
    assign busy     = in_burst;
    assign own_vld  = in_burst && vld_x[gnt_id];
    assign own_rd   = !we_x[gnt_id];

    // A read is withheld from memory entirely while there is no room to remember its owner.
    assign mem_req   = own_vld && !(own_rd && tagq_full);
    assign accept    = mem_req && mem_ready;
    assign req_ready = accept ? (3'b001 << gnt_id) : 3'b000;
    assign mem_we    = in_burst && we_x[gnt_id];
    assign mem_addr  = in_burst ? addr_a[gnt_id] : '0;
    assign mem_wdata = in_burst ? wdata_a[gnt_id] : '0;

    assign last_beat = accept && (beat_cnt == 4'd1);
    assign wdog_fire = in_burst && !vld_x[gnt_id] && (wdog_cnt == WDOG_W'(WDOG - 1));
    assign next_rr   = (gnt_id == 2'd2) ? 2'd0 : gnt_id + 2'd1;
    assign tag_push  = accept && own_rd;

    fifo #(
        .WIDTH (2),
        .DEPTH (TAGQ_DEPTH)
    ) u_tagq (
        .clk    (wb_clk_i),
        .rst    (wb_rst_i),
        .wr_vld (tag_push),
        .wr_dat (gnt_id),
        .rd_rdy (mem_rvalid),
        .rd_dat (tag_head),
        .full   (tagq_full),
        .empty  (tagq_empty)
    );

    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            state     <= IDLE;
            gnt_id    <= 2'd0;
            rr_ptr    <= 2'd0;
            beat_cnt  <= 4'd0;
            wdog_cnt  <= '0;
            err_abort <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (|req_valid) begin
                        state    <= BURST;
                        gnt_id   <= sel;
                        beat_cnt <= {1'b0, len_a[sel]} + 4'd1;
                        wdog_cnt <= '0;
                    end
                end
                default: begin
                    if (accept) beat_cnt <= beat_cnt - 4'd1;
                    if (vld_x[gnt_id])
                        wdog_cnt <= '0;
                    else
                        wdog_cnt <= wdog_cnt + WDOG_W'(1);
                    // Completion and abort both hand priority to the next requester.
                    if (last_beat || wdog_fire) begin
                        state  <= IDLE;
                        rr_ptr <= next_rr;
                    end
                    if (wdog_fire) err_abort <= 1'b1;
                end
            endcase
        end
    end

    // Read returns are routed by the oldest outstanding owner; a return with no owner is flagged and dropped.
    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            rsp_valid  <= 3'b000;
            rsp_rdata  <= 32'd0;
            err_orphan <= 1'b0;
        end else begin
            rsp_valid <= 3'b000;
            if (mem_rvalid) begin
                if (tagq_empty) begin
                    err_orphan <= 1'b1;
                end else begin
                    rsp_valid <= 3'b001 << tag_head;
                    rsp_rdata <= mem_rdata;
                end
            end
        end
    end
endmodule

// File: tb/tb_mem_arbiter.sv
module tb_mem_arbiter;
    localparam int AW = 23;

    logic            wb_clk_i;
    logic            wb_rst_i;
    logic [2:0]      req_valid;
    logic [2:0]      req_we;
    logic [8:0]      req_len;
    logic [3*AW-1:0] req_addr;
    logic [95:0]     req_wdata;
    logic [2:0]      req_ready;
    logic [2:0]      rsp_valid;
    logic [31:0]     rsp_rdata;
    logic            mem_req;
    logic            mem_we;
    logic [AW-1:0]   mem_addr;
    logic [31:0]     mem_wdata;
    logic            mem_ready;
    logic            mem_rvalid;
    logic [31:0]     mem_rdata;
    logic [1:0]      gnt_id;
    logic            busy;
    logic            err_orphan;
    logic            err_abort;

    int checks = 0;
    int errors = 0;

    // Memory responder: automatic (read latency 2) or manually driven.
    logic        auto_rsp = 1'b0;
    logic        auto_rv = 1'b0;
    logic [31:0] auto_rd = 32'd0;
    logic        s1_v = 1'b0;
    logic [31:0] s1_d = 32'd0;
    logic        acc_v = 1'b0;
    logic [31:0] acc_d = 32'd0;
    logic        man_rv = 1'b0;
    logic [31:0] man_rd = 32'd0;

    assign mem_rvalid = auto_rsp ? auto_rv : man_rv;
    assign mem_rdata  = auto_rsp ? auto_rd : man_rd;

    mem_arbiter #(.ADDR_W(AW), .TAGQ_DEPTH(4), .WDOG(16)) dut (
        .wb_clk_i(wb_clk_i), .wb_rst_i(wb_rst_i),
        .req_valid(req_valid), .req_we(req_we), .req_len(req_len),
        .req_addr(req_addr), .req_wdata(req_wdata), .req_ready(req_ready),
        .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_ready(mem_ready), .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata),
        .gnt_id(gnt_id), .busy(busy), .err_orphan(err_orphan), .err_abort(err_abort)
    );

    initial wb_clk_i = 1'b0;
    always #5 wb_clk_i = ~wb_clk_i;

    always @(negedge wb_clk_i) begin
        acc_v = mem_req && mem_ready && !mem_we;
        acc_d = 32'hD000_0000 + {9'b0, mem_addr};
    end

    always @(posedge wb_clk_i) begin
        #1;
        if (auto_rsp) begin
            auto_rv = s1_v;
            auto_rd = s1_d;
            s1_v    = acc_v;
            s1_d    = acc_d;
        end else begin
            auto_rv = 1'b0;
            s1_v    = 1'b0;
        end
    end

    initial begin
        #100000;
        $display("FAIL global_timeout simulation did not finish");
        $fatal(1);
    end

    task automatic reset_dut();
        wb_rst_i  = 1'b1;
        auto_rsp  = 1'b0;
        man_rv    = 1'b0;
        man_rd    = 32'd0;
        req_valid = 3'b000;
        req_we    = 3'b000;
        req_len   = 9'd0;
        req_addr  = '0;
        req_wdata = '0;
        mem_ready = 1'b1;
        repeat (2) @(posedge wb_clk_i);
        #1 wb_rst_i = 1'b0;
    endtask

    task automatic test_reset();
        wb_rst_i  = 1'b1;
        req_valid = 3'b111;
        req_we    = 3'b000;
        req_len   = 9'd0;
        req_addr  = '0;
        req_wdata = '0;
        mem_ready = 1'b1;
        man_rv    = 1'b1;
        man_rd    = 32'hFFFF_FFFF;
        repeat (3) @(posedge wb_clk_i);
        @(negedge wb_clk_i);
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %0h want 0", busy); end
        checks++;
        if ({req_ready, rsp_valid, rsp_rdata, mem_req, mem_we, mem_addr, mem_wdata, gnt_id, busy, err_orphan, err_abort} !== 100'd0) begin
            errors++;
            $display("FAIL reset_outputs got rdy=%h rsp=%h rd=%h req=%h we=%h a=%h wd=%h g=%h eo=%h ea=%h want all 0",
                     req_ready, rsp_valid, rsp_rdata, mem_req, mem_we, mem_addr, mem_wdata, gnt_id, err_orphan, err_abort);
        end
        man_rv = 1'b0;
    endtask

    task automatic test_read_burst();
        logic [9:0] e_busy;
        logic [9:0] e_rsp;
        int acc;
        int rsp_n;
        reset_dut();
        auto_rsp = 1'b1;
        e_busy = 10'b0000011110;
        e_rsp  = 10'b0011110000;
        acc = 0;
        rsp_n = 0;
        for (int c = 0; c < 10; c++) begin
            req_valid = (acc < 4) ? 3'b001 : 3'b000;
            req_we    = 3'b000;
            req_len   = 9'd3;
            req_addr  = '0;
            req_addr[AW-1:0] = AW'(32'h100 + acc);
            @(negedge wb_clk_i);
            checks++; if (busy !== e_busy[c]) begin errors++; $display("FAIL rd_busy c%0d got %0h want %0h", c, busy, e_busy[c]); end
            checks++; if (mem_req !== e_busy[c]) begin errors++; $display("FAIL rd_mem_req c%0d got %0h want %0h", c, mem_req, e_busy[c]); end
            checks++; if (rsp_valid !== {2'b00, e_rsp[c]}) begin errors++; $display("FAIL rd_rsp_valid c%0d got %0h want %0h", c, rsp_valid, {2'b00, e_rsp[c]}); end
            if (e_busy[c]) begin
                checks++; if (mem_addr !== AW'(32'h100 + c - 1)) begin errors++; $display("FAIL rd_addr c%0d got %0h want %0h", c, mem_addr, AW'(32'h100 + c - 1)); end
            end
            if (rsp_valid[0]) begin
                checks++; if (rsp_rdata !== 32'hD000_0100 + rsp_n) begin errors++; $display("FAIL rd_data n%0d got %0h want %0h", rsp_n, rsp_rdata, 32'hD000_0100 + rsp_n); end
                rsp_n++;
            end
            if (req_ready[0]) acc++;
            @(posedge wb_clk_i); #1;
        end
        checks++; if (acc != 4) begin errors++; $display("FAIL rd_beats got %0d want 4", acc); end
        checks++; if (rsp_n != 4) begin errors++; $display("FAIL rd_rsp_count got %0d want 4", rsp_n); end
    endtask

    task automatic test_rotation();
        logic [1:0] exp_g [6];
        int k;
        reset_dut();
        exp_g = '{2'd0, 2'd1, 2'd2, 2'd0, 2'd1, 2'd2};
        req_valid = 3'b111;
        req_we    = 3'b111;
        req_len   = 9'd0;
        req_wdata = {32'hAAAA_0002, 32'hAAAA_0001, 32'hAAAA_0000};
        for (int c = 0; c < 12; c++) begin
            @(negedge wb_clk_i);
            if (c % 2 == 1) begin
                k = (c - 1) / 2;
                checks++; if (busy !== 1'b1) begin errors++; $display("FAIL rot_busy c%0d got %0h want 1", c, busy); end
                checks++; if (gnt_id !== exp_g[k]) begin errors++; $display("FAIL rot_gnt c%0d got %0h want %0h", c, gnt_id, exp_g[k]); end
                checks++; if (req_ready !== (3'b001 << exp_g[k])) begin errors++; $display("FAIL rot_ready c%0d got %0h want %0h", c, req_ready, 3'b001 << exp_g[k]); end
                checks++; if (mem_wdata !== 32'hAAAA_0000 + 32'(exp_g[k])) begin errors++; $display("FAIL rot_wdata c%0d got %0h want %0h", c, mem_wdata, 32'hAAAA_0000 + 32'(exp_g[k])); end
            end else begin
                checks++; if ({busy, mem_req, req_ready} !== 5'b0) begin errors++; $display("FAIL rot_idle_gap c%0d got %0h want 0", c, {busy, mem_req, req_ready}); end
            end
            @(posedge wb_clk_i); #1;
        end
    endtask

    task automatic test_tagq_full();
        int acc;
        reset_dut();
        acc = 0;
        req_valid = 3'b010;
        req_we    = 3'b000;
        req_len   = {3'd0, 3'd7, 3'd0};
        for (int c = 0; c < 11; c++) begin
            man_rv = (c == 8);
            man_rd = 32'h5555_0001;
            @(negedge wb_clk_i);
            if (c == 7) begin
                checks++; if (acc != 4) begin errors++; $display("FAIL tagq_fill got %0d want 4", acc); end
                checks++; if (mem_req !== 1'b0) begin errors++; $display("FAIL tagq_block got %0h want 0", mem_req); end
            end
            if (c == 9) begin
                checks++; if (rsp_valid !== 3'b010) begin errors++; $display("FAIL tagq_rsp_valid got %0h want 2", rsp_valid); end
                checks++; if (rsp_rdata !== 32'h5555_0001) begin errors++; $display("FAIL tagq_rsp_data got %0h want 55550001", rsp_rdata); end
            end
            if (c == 10) begin
                checks++; if (mem_req !== 1'b0) begin errors++; $display("FAIL tagq_reblock got %0h want 0", mem_req); end
            end
            if (req_ready[1]) acc++;
            @(posedge wb_clk_i); #1;
        end
        man_rv = 1'b0;
        checks++; if (acc != 5) begin errors++; $display("FAIL tagq_one_more got %0d want 5", acc); end
    endtask

    task automatic test_watchdog();
        logic held_ok;
        reset_dut();
        held_ok   = 1'b1;
        req_we    = 3'b111;
        req_len   = {3'd3, 3'd0, 3'd0};
        for (int c = 0; c < 27; c++) begin
            case (c)
                0, 1:    req_valid = 3'b010;
                2, 8:    req_valid = 3'b100;
                25:      req_valid = 3'b111;
                default: req_valid = 3'b000;
            endcase
            mem_ready = (c != 8);
            @(negedge wb_clk_i);
            if (c >= 3 && c <= 24 && (busy !== 1'b1 || gnt_id !== 2'd2)) held_ok = 1'b0;
            if (c == 24) begin
                checks++; if (err_abort !== 1'b0) begin errors++; $display("FAIL wdog_early_abort got %0h want 0", err_abort); end
            end
            if (c == 25) begin
                checks++; if (busy !== 1'b0) begin errors++; $display("FAIL wdog_idle got %0h want 0", busy); end
                checks++; if (err_abort !== 1'b1) begin errors++; $display("FAIL wdog_err_abort got %0h want 1", err_abort); end
            end
            if (c == 26) begin
                checks++; if ({busy, gnt_id} !== 3'b100) begin errors++; $display("FAIL wdog_next_gnt got busy=%0h gnt=%0h want busy=1 gnt=0", busy, gnt_id); end
            end
            @(posedge wb_clk_i); #1;
        end
        checks++; if (held_ok !== 1'b1) begin errors++; $display("FAIL wdog_hold got %0h want 1", held_ok); end
    endtask

    task automatic test_orphan();
        reset_dut();
        for (int c = 0; c < 3; c++) begin
            man_rv = (c == 0);
            man_rd = 32'hBAD0_BAD0;
            @(negedge wb_clk_i);
            if (c == 0) begin
                checks++; if ({err_orphan, err_abort} !== 2'b00) begin errors++; $display("FAIL orph_pre got %0h want 0", {err_orphan, err_abort}); end
            end else begin
                checks++; if (err_orphan !== 1'b1) begin errors++; $display("FAIL orph_flag c%0d got %0h want 1", c, err_orphan); end
            end
            checks++; if (rsp_valid !== 3'b000) begin errors++; $display("FAIL orph_rsp c%0d got %0h want 0", c, rsp_valid); end
            @(posedge wb_clk_i); #1;
        end
        man_rv = 1'b0;
    endtask

    task automatic test_reset_mid_burst();
        reset_dut();
        req_valid = 3'b001;
        req_we    = 3'b001;
        req_len   = 9'd3;
        req_addr  = '0;
        req_addr[AW-1:0] = AW'(32'h40);
        req_wdata = {64'd0, 32'h1234_5678};
        repeat (2) begin
            @(negedge wb_clk_i);
            @(posedge wb_clk_i); #1;
        end
        @(negedge wb_clk_i);
        checks++; if ({busy, mem_req, mem_wdata} !== {2'b11, 32'h1234_5678}) begin errors++; $display("FAIL mrst_beat2 got %0h want %0h", {busy, mem_req, mem_wdata}, {2'b11, 32'h1234_5678}); end
        #1 wb_rst_i = 1'b1;
        #1;
        checks++;
        if ({req_ready, rsp_valid, rsp_rdata, mem_req, mem_we, mem_addr, mem_wdata, gnt_id, busy, err_orphan, err_abort} !== 100'd0) begin
            errors++;
            $display("FAIL mrst_outputs got rdy=%h req=%h we=%h a=%h wd=%h g=%h busy=%h want all 0",
                     req_ready, mem_req, mem_we, mem_addr, mem_wdata, gnt_id, busy);
        end
        @(posedge wb_clk_i); #1;
        wb_rst_i  = 1'b0;
        req_valid = 3'b010;
        req_we    = 3'b010;
        req_len   = 9'd0;
        @(negedge wb_clk_i);
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL mrst_idle got %0h want 0", busy); end
        @(posedge wb_clk_i); #1;
        @(negedge wb_clk_i);
        checks++; if ({busy, gnt_id, req_ready} !== {1'b1, 2'd1, 3'b010}) begin errors++; $display("FAIL mrst_regrant got %0h want %0h", {busy, gnt_id, req_ready}, {1'b1, 2'd1, 3'b010}); end
        @(posedge wb_clk_i); #1;
        req_valid = 3'b000;
    endtask

    initial begin
        test_reset();
        test_read_burst();
        test_rotation();
        test_tagq_full();
        test_watchdog();
        test_orphan();
        test_reset_mid_burst();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 Parameter ADDR_W, 23, word address width of requester and memory ports, in bits.
REQ-002 Parameter TAGQ_DEPTH, 4, depth of the outstanding-read owner queue (power of 2).
REQ-003 Parameter WDOG, 16, number of idle cycles inside a burst before that burst is aborted.
REQ-004 wb_clk_i  in  1  single clock; all logic rising-edge.
REQ-005 wb_rst_i  in  1  reset, asynchronous assert, active-high.
REQ-006 req_valid  in  3  per-requester beat request; 0=CPU, 1=FIR DMA, 2=matmul/qsort DMA.
REQ-007 req_we  in  3  per-requester write enable.
REQ-008 req_len  in  9  per-requester burst length minus 1, 3 bits each, sampled at grant.
REQ-009 req_addr  in  3*ADDR_W  per-requester beat address.
REQ-010 req_wdata  in  96  per-requester write data, 32 bits each.
REQ-011 req_ready  out  3  per-requester beat accepted this cycle.
REQ-012 rsp_valid  out  3  per-requester read data valid.
REQ-013 rsp_rdata  out  32  read data, shared by all requesters.
REQ-014 mem_req / mem_we  out  1/1  shared memory beat request and direction.
REQ-015 mem_addr / mem_wdata  out  ADDR_W/32  beat address and write data.
REQ-016 mem_ready  in  1  memory accepts the beat this cycle.
REQ-017 mem_rvalid / mem_rdata  in  1/32  in-order read return.
REQ-018 gnt_id / busy  out  2/1  current owner and burst-in-progress flag.
REQ-019 err_orphan / err_abort  out  1/1  sticky error flags.

Function
REQ-020 The FSM shall have the states IDLE and BURST.
REQ-021 In IDLE with any req_valid asserted, the block shall select the first asserted index at or after rr_ptr (mod 3), latch gnt_id and the beat count (req_len+1), and enter BURST on the next edge.
REQ-022 First mem_req shall occur 1 cycle after req_valid is seen in IDLE; no beat is accepted while in IDLE.
REQ-023 In BURST, mem_req shall equal req_valid[gnt_id], and mem_we/addr/wdata shall be muxed combinationally from gnt_id.
REQ-024 req_ready[gnt_id] shall equal mem_req && mem_ready && !(read && tagq_full); mem_req shall be forced low when a read is blocked by a full tag queue; non-owners shall see req_ready=0.
REQ-025 Each accepted beat shall decrement the count; acceptance of the last beat shall set rr_ptr=(gnt_id+1) mod 3 and return to IDLE, with no turnaround beat in the same cycle.
REQ-026 Each accepted read beat shall push gnt_id into the tag queue; a push when full is impossible by REQ-024.
REQ-027 Each mem_rvalid shall pop the queue and drive rsp_valid[tag]=1 and rsp_rdata=mem_rdata, registered, one cycle after mem_rvalid.
REQ-028 A push and a pop in the same cycle shall both take effect, leaving occupancy unchanged.
REQ-029 mem_rvalid while the queue is empty shall be ignored, with no rsp_valid, and shall set err_orphan.
REQ-030 Outstanding reads shall continue to drain across grant changes and IDLE.
REQ-031 In BURST, WDOG consecutive cycles with req_valid[gnt_id]=0 shall abort the burst: return to IDLE, advance rr_ptr, and set err_abort.
REQ-032 The watchdog counter shall clear on any cycle with req_valid[gnt_id]=1.
REQ-033 busy shall be 1 exactly in BURST.
REQ-034 Writes produce no response.

Reset
REQ-035 While wb_rst_i=1: state=IDLE, rr_ptr=0, tag queue empty, counters 0, and all outputs 0 (including gnt_id, errors, and rsp_rdata).
REQ-036 Reset mid-burst shall discard remaining beats and pending tags; returns arriving after release shall set err_orphan.
REQ-037 Error flags shall clear only on reset.

Verification
REQ-038 Requester 0 only, 4-beat read (len=3), mem_ready=1, rvalid latency 2 -> mem_req from cycle 1; 4 rsp_valid[0] pulses carrying the data in order; busy falls after beat 4.
REQ-039 All three requesters request len=0 continuously -> grants rotate 0,1,2,0,1,2; each beat is separated by one IDLE cycle.
REQ-040 Requester 1 issues an 8-beat read with memory holding rvalid off -> exactly 4 beats accepted and mem_req low; after one rvalid, one more beat is accepted the same or next cycle.
REQ-041 Requester 2 is granted, then req_valid drops for 16 cycles -> err_abort=1, IDLE, next grant goes to requester 0.
REQ-042 mem_rvalid with no outstanding read -> err_orphan=1 and rsp_valid stays 0.
REQ-043 wb_rst_i asserted for 1 cycle during beat 2 of a 4-beat write -> all outputs 0 immediately; after release, a new request from requester 1 is granted normally.
